// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and latency constants for the pipeline hazard sequencer.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MD_WAIT    = 2'd1,
    REDIR_PEND = 2'd2
  } hz_state_e;

  localparam int MUL_CYCLES_DEF = 3;
  localparam int DIV_CYCLES_DEF = 32;

  function automatic int md_cnt_w(input int mul_cycles, input int div_cycles);
    int mx;
    mx = (mul_cycles > div_cycles) ? mul_cycles : div_cycles;
    return (mx < 2) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_md_counter.sv
// MUL/DIV occupancy down-counter; done flags the last busy cycle.
module hazard_md_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Optional HAZARD_PERF_EN adds stall-cycle and flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_stall,
  input  logic              dcache_stall,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_md_start,
  input  logic              ex_md_is_div,
  input  logic              ex_predict_fail,
  input  logic [DATA_W-1:0] ex_redirect_pc,
  output logic              pc_write,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_redirect_target,
  output logic              if_id_hold,
  output logic              if_id_flush,
  output logic              id_ex_hold,
  output logic              id_ex_flush,
  output logic              ex_mem_hold,
  output logic              ex_mem_bubble,
  output logic              md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flush_count
`endif
);

  localparam int CNT_W = md_cnt_w(MUL_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES - 1);

  hz_state_e         state_q, state_d;
  logic [DATA_W-1:0] pend_pc_q, pend_pc_d;
  logic              md_load, md_dec, md_done, load_use;
  logic [CNT_W-1:0]  md_ld_val;

  assign md_ld_val = ex_md_is_div ? DIV_LD : MUL_LD;
  assign load_use  = ex_mem_read && (ex_rd != '0) &&
                     ((id_rs1_used && (id_rs1 == ex_rd)) ||
                      (id_rs2_used && (id_rs2 == ex_rd)));

  hazard_md_counter #(.CNT_W(CNT_W)) u_md_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (md_load),
    .load_val (md_ld_val),
    .dec      (md_dec),
    .done     (md_done)
  );

  always_comb begin
    pc_write           = 1'b1;
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    if_id_hold         = 1'b0;
    if_id_flush        = 1'b0;
    id_ex_hold         = 1'b0;
    id_ex_flush        = 1'b0;
    ex_mem_hold        = 1'b0;
    ex_mem_bubble      = 1'b0;
    md_busy            = 1'b0;
    md_load            = 1'b0;
    md_dec             = 1'b0;
    state_d            = state_q;
    pend_pc_d          = pend_pc_q;
    if (!rst) begin
      md_busy = (state_q == MD_WAIT);
      if (dcache_stall) begin
        // Freeze everything; a mispredict seen now is replayed after release.
        pc_write    = 1'b0;
        if_id_hold  = 1'b1;
        id_ex_hold  = 1'b1;
        ex_mem_hold = 1'b1;
        if (ex_predict_fail) begin
          state_d   = REDIR_PEND;
          pend_pc_d = ex_redirect_pc;
        end
      end else if ((state_q == REDIR_PEND) || ((state_q == RUN) && ex_predict_fail)) begin
        pc_redirect        = 1'b1;
        pc_redirect_target = (state_q == REDIR_PEND) ? pend_pc_q : ex_redirect_pc;
        if_id_flush        = 1'b1;
        id_ex_flush        = 1'b1;
        state_d            = RUN;
      end else if (state_q == MD_WAIT) begin
        pc_write      = 1'b0;
        if_id_hold    = 1'b1;
        id_ex_hold    = 1'b1;
        ex_mem_bubble = 1'b1;
        md_dec        = 1'b1;
        if (md_done) state_d = RUN;
      end else if (ex_md_start) begin
        md_load = 1'b1;
        if (md_ld_val != '0) state_d = MD_WAIT;
      end else if (load_use) begin
        pc_write    = 1'b0;
        if_id_hold  = 1'b1;
        id_ex_flush = 1'b1;
      end else if (icache_stall) begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // A branch cannot resolve in EX while MUL/DIV owns the stage.
  always_ff @(posedge clk) begin
    if (!rst) assert (!((state_q == MD_WAIT) && ex_predict_fail));
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (!pc_write)   perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (pc_redirect) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule
